// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered-output ALU between two requesters, round-robin, one op in flight
// Ports: clk, rst (asynchronous, active-high)
//   rq0_*/rq1_*  : valid/ready op channels carrying x, y and ctl {zx,nx,zy,ny,f,no}
//   alu_x/alu_y/alu_ctl : operands and control to the ALU; alu_out : its result one cycle later
//   resp_*       : valid/ready response carrying requester id, result and zr/ng flags
// Optional: define ALU_ARBITER_FLAGS_EN to build the zr/ng flags; otherwise both read 0.
module alu_arbiter #(
  parameter int W = 16,
  parameter int CTL_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rq0_valid,
  output logic             rq0_ready,
  input  logic [W-1:0]     rq0_x,
  input  logic [W-1:0]     rq0_y,
  input  logic [CTL_W-1:0] rq0_ctl,
  input  logic             rq1_valid,
  output logic             rq1_ready,
  input  logic [W-1:0]     rq1_x,
  input  logic [W-1:0]     rq1_y,
  input  logic [CTL_W-1:0] rq1_ctl,
  output logic [W-1:0]     alu_x,
  output logic [W-1:0]     alu_y,
  output logic [CTL_W-1:0] alu_ctl,
  input  logic [W-1:0]     alu_out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [W-1:0]     resp_out,
  output logic             resp_zr,
  output logic             resp_ng
);
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
  state_t           r_state;
  logic             r_prio;
  logic             r_op_id;
  logic [W-1:0]     r_alu_x;
  logic [W-1:0]     r_alu_y;
  logic [CTL_W-1:0] r_alu_ctl;
  logic             r_resp_valid;
  logic             r_resp_id;
  logic [W-1:0]     r_resp_out;
  logic             w_any;
  logic             w_win;
  logic             w_acc;
  assign w_any = rq0_valid | rq1_valid;
  // a lone requester wins outright; a tie goes to the priority pointer
  assign w_win = (rq0_valid & rq1_valid) ? r_prio : rq1_valid;
  // ready is held low while reset is asserted even though the state already reads IDLE
  assign w_acc = (r_state == IDLE) & w_any & ~rst;
  assign rq0_ready = w_acc & ~w_win;
  assign rq1_ready = w_acc & w_win;
  assign alu_x = r_alu_x;
  assign alu_y = r_alu_y;
  assign alu_ctl = r_alu_ctl;
  assign resp_valid = r_resp_valid;
  assign resp_id = r_resp_id;
  assign resp_out = r_resp_out;
  // the operand registers double as the ALU drive, so they hold the last op outside EXEC
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_prio <= 1'b0;
      r_op_id <= 1'b0;
      r_alu_x <= '0;
      r_alu_y <= '0;
      r_alu_ctl <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id <= 1'b0;
      r_resp_out <= '0;
    end else
      case (r_state)
        IDLE:
          if (w_any) begin
            r_state <= EXEC;
            r_prio <= ~w_win;
            r_op_id <= w_win;
            r_alu_x <= w_win ? rq1_x : rq0_x;
            r_alu_y <= w_win ? rq1_y : rq0_y;
            r_alu_ctl <= w_win ? rq1_ctl : rq0_ctl;
          end
        EXEC: r_state <= CAPT;
        CAPT: begin
          r_state <= RESP;
          r_resp_valid <= 1'b1;
          r_resp_out <= alu_out;
          r_resp_id <= r_op_id;
        end
        RESP:
          if (resp_ready) begin
            r_state <= IDLE;
            r_resp_valid <= 1'b0;
          end
        default: r_state <= IDLE;
      endcase
`ifdef ALU_ARBITER_FLAGS_EN
  logic r_resp_zr;
  logic r_resp_ng;
  // flags are sampled from alu_out on the same edge that captures resp_out
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_resp_zr <= 1'b0;
      r_resp_ng <= 1'b0;
    end else if (r_state == CAPT) begin
      r_resp_zr <= alu_out == '0;
      r_resp_ng <= alu_out[W-1];
    end
  assign resp_zr = r_resp_zr;
  assign resp_ng = r_resp_ng;
`else
  assign resp_zr = 1'b0;
  assign resp_ng = 1'b0;
`endif
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one clocked 16-bit ALU between two requesters (e.g. CPU execute stage and an address/DMA helper).
- Arbitrates round-robin, drives the ALU operand and control inputs, and waits out the ALU's one-cycle registered latency.
- Captures the result and returns it with requester ID over a valid/ready response channel.
- One operation in flight at a time. Sits between the requesters and the ALU instance.

Parameters:
W, 16, data width of operands and result
CTL_W, 6, control bits per op, packed {zx,nx,zy,ny,f,no} MSB..LSB

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous active-high reset
rq0_valid  in  1  requester 0 has an op
rq0_ready  out  1  requester 0 op accepted this cycle when valid&ready
rq0_x  in  W  operand x, requester 0
rq0_y  in  W  operand y, requester 0
rq0_ctl  in  CTL_W  ALU control, requester 0
rq1_valid  in  1  requester 1 has an op
rq1_ready  out  1  requester 1 op accepted this cycle when valid&ready
rq1_x  in  W  operand x, requester 1
rq1_y  in  W  operand y, requester 1
rq1_ctl  in  CTL_W  ALU control, requester 1
alu_x  out  W  to ALU x
alu_y  out  W  to ALU y
alu_ctl  out  CTL_W  to ALU zx/nx/zy/ny/f/no
alu_out  in  W  ALU registered result
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result when valid&ready
resp_id  out  1  requester that issued the op
resp_out  out  W  captured result
resp_zr  out  1  resp_out==0 (feature-dependent)
resp_ng  out  1  resp_out[W-1] (feature-dependent)

Behaviour:
- FSM states: IDLE, EXEC, CAPT, RESP. Reset state is IDLE.
- Reset values:
  - rqN_ready=0, resp_valid=0, resp_id=0, resp_out=0, resp_zr=0, resp_ng=0, alu_x/alu_y/alu_ctl=0.
  - Priority pointer prio=0.
- Ready generation: rqN_ready is combinational and asserted only in IDLE, and only for the arbitration winner. The loser's ready stays 0.
- Arbitration in IDLE:
  - If only one valid, that requester wins.
  - If both valid, requester prio wins.
  - On acceptance prio <= ~winner.
  - No valid: stay IDLE, prio unchanged.
- IDLE->EXEC on acceptance. The accepting edge latches x, y, ctl and id into the op registers.
- EXEC: alu_x/alu_y/alu_ctl are driven from the op registers (registered, stable throughout). The ALU samples them at the EXEC->CAPT edge.
- CAPT: alu_out is valid. The CAPT->RESP edge loads resp_out<=alu_out and resp_id<=op id; flags are computed from alu_out.
- RESP:
  - resp_valid=1; all resp_* held stable until resp_valid&resp_ready.
  - That edge returns to IDLE and resp_valid drops.
- Latency:
  - Accept edge at cycle 0 -> resp_valid high in cycle 3.
  - Minimum issue interval 4 cycles; a new accept is possible in the cycle after the handshake.
- alu_x/alu_y/alu_ctl keep the last op's values outside EXEC; the ALU output is ignored outside CAPT.
- Requesters may change valid/operands freely while not ready. Values present at the accept edge are the ones used.
- Simultaneous resp handshake and new request: the new request waits for IDLE (no bypass).
- resp_ready high before RESP has no effect.
- Reset mid-operation (any state): asynchronous return to IDLE with all reset values. The in-flight op is dropped and no response is produced.

Optional Feature:
Macro ALU_ARBITER_FLAGS_EN.
- Defined: resp_zr=(alu_out==0) and resp_ng=alu_out[W-1], both registered at the CAPT->RESP edge with resp_out.
- Undefined: no flag logic is built; resp_zr and resp_ng are tied to 0. All other behaviour is identical.

Test Plan:
- Single op: rq0 x=5, y=3, ctl=000010 (add), ALU model returns 8 one cycle after sampling. Expect:
  - resp_valid in cycle 3, resp_out=8, resp_id=0.
  - With flags: zr=0, ng=0.
- Contention: both valid from reset, each with a distinct op, resp_ready=1. Expect grants in order rq0, rq1, rq0, rq1; resp_id alternating 0,1,0,1; ready never high on both.
- Back-pressure: resp_ready=0 for 5 cycles in RESP. Expect resp_valid and resp_out held constant and rq0_ready/rq1_ready=0 throughout. Raise resp_ready: IDLE next cycle, new accept possible.
- Reset mid-EXEC: assert rst during EXEC. Expect immediate return to reset values, no resp_valid afterwards for that op, and the first post-reset tie goes to rq0.
- Flags (macro on): op result 0x0000 -> zr=1, ng=0. Op result 0x8000 -> zr=0, ng=1. Macro off -> both 0.
- Operand hold: rq1 changes x after acceptance, during EXEC. Expect alu_x to keep the accepted value throughout EXEC.
